mem_port_arbiter: RTL and testbench

Shares one single-port, variable-latency memory between the RV32I pipeline's instruction-fetch port and its data port. Each pipeline step is one fetch plus at most one data access. The block serialises these accesses with data first, then instruction. It holds the whole pipeline stalled until both accesses complete, then releases it for exactly one cycle. It also runs a per-access watchdog so a memory that never acknowledges cannot hang the core.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Serialises the RV32I data and fetch accesses onto one variable-latency memory port,
// stalling the pipeline for the whole step and aborting any access the memory never acknowledges.
module mem_port_arbiter #(
    parameter int              size     = 32,
    parameter int              TIMEOUT  = 255,
    parameter logic [size-1:0] NOP_INST = 'h00000013
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [size-1:0] inst_adr_i,
    output logic [size-1:0] inst_o,
    input  logic            d_rd_i,
    input  logic            d_wr_i,
    input  logic [size-1:0] data_adr_i,
    input  logic [size-1:0] data_out_i,
    output logic [size-1:0] data_in_o,
    output logic            stall_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [size-1:0] mem_addr_o,
    output logic [size-1:0] mem_wdata_o,
    input  logic [size-1:0] mem_rdata_i,
    input  logic            mem_ack_i,
    output logic            err_o
);

    typedef enum logic [1:0] {ARB, DACC, IACC, REL} state_e;

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [size-1:0] instAdr_q, instAdr_d;
    logic            memReq_q, memReq_d;
    logic            memWe_q, memWe_d;
    logic [size-1:0] memAddr_q, memAddr_d;
    logic [size-1:0] memWdata_q, memWdata_d;
    logic [size-1:0] inst_q, inst_d;
    logic [size-1:0] data_q, data_d;
    logic            err_q, err_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            expire;

    // An ack in the final watchdog cycle wins over the abort.
    assign expire = !mem_ack_i && (cnt_q == LAST_CNT);

    always_comb begin
        state_d    = state_q;
        instAdr_d  = instAdr_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        inst_d     = inst_q;
        data_d     = data_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            ARB: begin
                instAdr_d = inst_adr_i;
                memReq_d  = 1'b1;
                cnt_d     = '0;
                if (d_rd_i || d_wr_i) begin
                    state_d    = DACC;
                    memWe_d    = d_wr_i;
                    memAddr_d  = data_adr_i;
                    memWdata_d = data_out_i;
                end else begin
                    state_d   = IACC;
                    memWe_d   = 1'b0;
                    memAddr_d = inst_adr_i;
                end
            end
            DACC: begin
                if (mem_ack_i || expire) begin
                    if (!memWe_q) begin
                        data_d = mem_ack_i ? mem_rdata_i : '0;
                    end
                    if (expire) begin
                        err_d = 1'b1;
                    end
                    state_d   = IACC;
                    memWe_d   = 1'b0;
                    memAddr_d = instAdr_q;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            IACC: begin
                if (mem_ack_i || expire) begin
                    inst_d = mem_ack_i ? mem_rdata_i : NOP_INST;
                    if (expire) begin
                        err_d = 1'b1;
                    end
                    state_d  = REL;
                    memReq_d = 1'b0;
                    memWe_d  = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            REL: begin
                state_d = ARB;
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB;
            instAdr_q  <= '0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            inst_q     <= NOP_INST;
            data_q     <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            instAdr_q  <= instAdr_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            inst_q     <= inst_d;
            data_q     <= data_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign stall_o     = (state_q != REL);
    assign mem_req_o   = memReq_q;
    assign mem_we_o    = memWe_q;
    assign mem_addr_o  = memAddr_q;
    assign mem_wdata_o = memWdata_q;
    assign inst_o      = inst_q;
    assign data_in_o   = data_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a latency-programmable memory responder plus a per-step
// timeline model of what every output must show on every cycle.
module tb_mem_port_arbiter;

    localparam int          TO  = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instAdr = '0, dataAdr = '0, dataOut = '0, memRdata = '0;
    logic        dRd = 1'b0, dWr = 1'b0, memAck = 1'b0;
    logic [31:0] inst, dataIn, memAddr, memWdata;
    logic        stall, memReq, memWe, err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.size(32), .TIMEOUT(TO), .NOP_INST(NOP)) dut (
        .clk_i(clk), .rst_ni(rst_n), .inst_adr_i(instAdr), .inst_o(inst),
        .d_rd_i(dRd), .d_wr_i(dWr), .data_adr_i(dataAdr), .data_out_i(dataOut),
        .data_in_o(dataIn), .stall_o(stall), .mem_req_o(memReq), .mem_we_o(memWe),
        .mem_addr_o(memAddr), .mem_wdata_o(memWdata), .mem_rdata_i(memRdata),
        .mem_ack_i(memAck), .err_o(err)
    );

    typedef struct {
        bit          req, we, stall, chkW, err;
        logic [31:0] addr, wdata, inst, data;
    } cyc_t;

    cyc_t        timeline[$];
    logic [31:0] memArr [logic [31:0]];
    int          latency = 1;
    bit          noAck = 1'b0;
    int          reqCnt = 0;
    int          compared = 0, mismatched = 0;
    int          stepCycles = 0, lastStepLen = 0;
    logic [31:0] mInst = NOP, mData = '0;
    bit          mErr = 1'b0;

    function automatic logic [31:0] rdMem(input logic [31:0] a);
        return memArr.exists(a) ? memArr[a] : 32'hBADC0DE0;
    endfunction

    function automatic cyc_t mkCyc(input bit req, we, stl, input logic [31:0] a, w, input bit chkW);
        cyc_t c;
        c.req = req; c.we = we; c.stall = stl; c.addr = a; c.wdata = w; c.chkW = chkW;
        c.inst = mInst; c.data = mData; c.err = mErr;
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory acks the L-th cycle of each access; writes land in memArr on the ack.
    always @(negedge clk) begin
        if (rst_n && memReq) begin
            reqCnt++;
            memAck   = !noAck && (reqCnt == latency);
            memRdata = memAck ? rdMem(memAddr) : 32'hBADC0DE0;
            if (memAck) begin
                if (memWe) memArr[memAddr] = memWdata;
                reqCnt = 0;
            end
        end else begin
            reqCnt   = 0;
            memAck   = 1'b0;
            memRdata = 32'hBADC0DE0;
        end
    end

    always @(negedge clk) begin
        cyc_t e;
        if (rst_n) begin
            stepCycles++;
            if (stall === 1'b0) begin
                lastStepLen = stepCycles;
                stepCycles  = 0;
            end
            if (timeline.size() > 0) begin
                e = timeline.pop_front();
                checkOutput("cyc.stall", 32'(stall), 32'(e.stall));
                checkOutput("cyc.req", 32'(memReq), 32'(e.req));
                checkOutput("cyc.we", 32'(memWe), 32'(e.we));
                if (e.req) checkOutput("cyc.addr", memAddr, e.addr);
                if (e.chkW) checkOutput("cyc.wdata", memWdata, e.wdata);
                checkOutput("cyc.inst", inst, e.inst);
                checkOutput("cyc.data", dataIn, e.data);
                checkOutput("cyc.err", 32'(err), 32'(e.err));
            end
        end
    end

    // Called while the DUT sits in ARB; builds the expected cycle-by-cycle step.
    task automatic applyStimulus(input bit rd, wr, input logic [31:0] dA, dO, iA,
                                 input int lat, input bit drop);
        bit ok;
        int dur;
        bit wPend = 1'b0;
        dRd = rd; dWr = wr; dataAdr = dA; dataOut = dO; instAdr = iA;
        latency = lat; noAck = drop;
        ok  = !drop && (lat <= TO);
        dur = ok ? lat : TO;
        timeline.push_back(mkCyc(1'b0, 1'b0, 1'b1, '0, '0, 1'b0));
        if (rd || wr) begin
            repeat (dur) timeline.push_back(mkCyc(1'b1, wr, 1'b1, dA, dO, 1'b1));
            if (!ok) mErr = 1'b1;
            if (wr) wPend = ok;
            else    mData = ok ? rdMem(dA) : 32'h0;
        end
        repeat (dur) timeline.push_back(mkCyc(1'b1, 1'b0, 1'b1, iA, '0, 1'b0));
        if (ok) begin
            mInst = (wPend && iA == dA) ? dO : rdMem(iA);
        end else begin
            mInst = NOP;
            mErr  = 1'b1;
        end
        timeline.push_back(mkCyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0));
    endtask

    task automatic waitStepDone();
        int guard = 0;
        while (timeline.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        if (timeline.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL step.timeout: %0d cycles pending, expected 0", timeline.size());
            timeline.delete();
        end
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.stall", 32'(stall), 32'd1);
        checkOutput("rst.req", 32'(memReq), 32'd0);
        checkOutput("rst.we", 32'(memWe), 32'd0);
        checkOutput("rst.addr", memAddr, 32'h0);
        checkOutput("rst.wdata", memWdata, 32'h0);
        checkOutput("rst.inst", inst, 32'h00000013);
        checkOutput("rst.data", dataIn, 32'h0);
        checkOutput("rst.err", 32'(err), 32'd0);
        timeline.delete();
        mInst = NOP; mData = '0; mErr = 1'b0;
        rst_n = 1'b1;
        stepCycles = 0;
    endtask

    initial begin
        memArr[32'h100]  = 32'h00500093;
        memArr[32'h104]  = 32'h00A00113;
        memArr[32'h108]  = 32'h00000513;
        memArr[32'h2000] = 32'hDEADBEEF;

        doReset();

        applyStimulus(1'b0, 1'b0, '0, '0, 32'h100, 1, 1'b0);
        waitStepDone();
        checkOutput("fetchL1.inst", inst, 32'h00500093);
        checkOutput("fetchL1.len", lastStepLen, 32'd3);

        applyStimulus(1'b1, 1'b0, 32'h2000, '0, 32'h104, 2, 1'b0);
        waitStepDone();
        checkOutput("load.data", dataIn, 32'hDEADBEEF);
        checkOutput("load.inst", inst, 32'h00A00113);
        checkOutput("load.len", lastStepLen, 32'd6);

        applyStimulus(1'b0, 1'b1, 32'h2004, 32'h12345678, 32'h108, 2, 1'b0);
        waitStepDone();
        checkOutput("store.data", dataIn, 32'hDEADBEEF);
        checkOutput("store.mem", rdMem(32'h2004), 32'h12345678);
        checkOutput("store.inst", inst, 32'h00000513);

        applyStimulus(1'b0, 1'b0, '0, '0, 32'h10C, 1, 1'b1);
        waitStepDone();
        checkOutput("wdog.inst", inst, 32'h00000013);
        checkOutput("wdog.err", 32'(err), 32'd1);
        checkOutput("wdog.len", lastStepLen, 32'd6);

        applyStimulus(1'b0, 1'b0, '0, '0, 32'h100, 1, 1'b0);
        waitStepDone();
        checkOutput("afterWdog.inst", inst, 32'h00500093);
        checkOutput("afterWdog.err", 32'(err), 32'd1);

        applyStimulus(1'b1, 1'b0, 32'h2000, '0, 32'h104, 1, 1'b1);
        waitStepDone();
        checkOutput("abortRd.data", dataIn, 32'h0);
        checkOutput("abortRd.len", lastStepLen, 32'd10);

        applyStimulus(1'b0, 1'b1, 32'h2008, 32'hCAFEF00D, 32'h100, 1, 1'b1);
        waitStepDone();
        checkOutput("abortWr.mem", 32'(memArr.exists(32'h2008)), 32'd0);

        doReset();
        applyStimulus(1'b1, 1'b0, 32'h2000, '0, 32'h104, 4, 1'b0);
        waitStepDone();
        checkOutput("lastCycAck.data", dataIn, 32'hDEADBEEF);
        checkOutput("lastCycAck.err", 32'(err), 32'd0);
        checkOutput("lastCycAck.len", lastStepLen, 32'd10);

        applyStimulus(1'b1, 1'b1, 32'h200C, 32'h55AA55AA, 32'h200C, 1, 1'b0);
        waitStepDone();
        checkOutput("rdWr.inst", inst, 32'h55AA55AA);
        checkOutput("rdWr.data", dataIn, 32'hDEADBEEF);

        // Reset pulse in the second DACC cycle of a latency-5 load.
        dRd = 1'b1; dWr = 1'b0; dataAdr = 32'h2000; instAdr = 32'h100;
        latency = 5; noAck = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        checkOutput("midRst.preReq", 32'(memReq), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midRst.req", 32'(memReq), 32'd0);
        checkOutput("midRst.stall", 32'(stall), 32'd1);
        checkOutput("midRst.err", 32'(err), 32'd0);
        checkOutput("midRst.inst", inst, 32'h00000013);
        doReset();
        applyStimulus(1'b0, 1'b0, '0, '0, 32'h104, 1, 1'b0);
        waitStepDone();
        checkOutput("postRst.inst", inst, 32'h00A00113);
        checkOutput("postRst.len", lastStepLen, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
